// File: rtl/apb_gpio.sv
// apb_gpio: 32-bit general-purpose I/O block on an APB slave port.
// Holds an output-data register and a direction register. Samples the
// external pins through a two-flop synchronizer. Every register is
// reachable with zero-wait-state APB transfers.
module apb_gpio #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'h4750_4901
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [3:0]            PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_dir,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY
);

  localparam logic [3:0] ADDR_ID       = 4'h0;
  localparam logic [3:0] ADDR_DATA_IN  = 4'h1;
  localparam logic [3:0] ADDR_DATA_OUT = 4'h2;
  localparam logic [3:0] ADDR_DIR      = 4'h3;

  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] dir_reg;
  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync_in;

  logic                  wr_stb;
  logic                  rd_sel;
  logic [DATA_WIDTH-1:0] rd_data;

  // Pin readback: output-configured bits show the value being driven, so
  // an undriven or X pin never leaks into those bit positions.
  function automatic logic [DATA_WIDTH-1:0] pin_readback(
    input logic [DATA_WIDTH-1:0] pins,
    input logic [DATA_WIDTH-1:0] drv,
    input logic [DATA_WIDTH-1:0] dir
  );
    return (pins & ~dir) | (drv & dir);
  endfunction

  // Register-map decode for reads; unmapped words read as zero.
  function automatic logic [DATA_WIDTH-1:0] reg_decode(
    input logic [3:0]            addr,
    input logic [DATA_WIDTH-1:0] pins,
    input logic [DATA_WIDTH-1:0] drv,
    input logic [DATA_WIDTH-1:0] dir
  );
    logic [DATA_WIDTH-1:0] val;
    case (addr)
      ADDR_ID:       val = ID_VALUE;
      ADDR_DATA_IN:  val = pin_readback(pins, drv, dir);
      ADDR_DATA_OUT: val = drv;
      ADDR_DIR:      val = dir;
      default:       val = '0;
    endcase
    return val;
  endfunction

  // Every cycle with PSEL and PENABLE high is a complete transfer, so a
  // held-high select/enable pair yields back-to-back writes.
  assign wr_stb = PSEL & PENABLE & PWRITE;
  assign rd_sel = PSEL & ~PWRITE;

  // Output and direction registers; writes to read-only or unmapped
  // words fall through and leave both registers untouched.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      out_reg <= '0;
      dir_reg <= '0;
    end else if (wr_stb) begin
      case (PADDR)
        ADDR_DATA_OUT: out_reg <= PWDATA;
        ADDR_DIR:      dir_reg <= PWDATA;
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous input pins.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1   <= '0;
      sync_in <= '0;
    end else begin
      sync1   <= gpio_in;
      sync_in <= sync1;
    end
  end

  // Combinational read data, valid in both setup and access phases.
  // It is zero whenever no read is presented.
  always_comb begin
    rd_data = '0;
    if (rd_sel) begin
      rd_data = reg_decode(PADDR, sync_in, out_reg, dir_reg);
    end
  end

  assign PRDATA   = rd_data;
  assign PREADY   = 1'b1;
  // Input-configured bits always drive 0. Writing DIR re-masks the pins
  // without disturbing out_reg.
  assign gpio_out = out_reg & dir_reg;
  assign gpio_dir = dir_reg;

endmodule

// File: tb/tb_apb_gpio.sv
// tb_apb_gpio: table-driven directed vectors, a reset-in-transfer
// sequence and randomized traffic against a behavioural model of apb_gpio.
module tb_apb_gpio;

  localparam logic [31:0] ID = 32'h4750_4901;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic [3:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_dir;
  logic [31:0] PRDATA;
  logic        PREADY;

  apb_gpio #(.DATA_WIDTH(32), .ID_VALUE(ID)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_dir (gpio_dir),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model: register values plus the history of pin samples
  // taken at each rising edge (a read sees the sample from two edges back).
  logic [31:0] m_out;
  logic [31:0] m_dir;
  logic [31:0] pin_hist[$];

  typedef struct packed {
    logic        sel;
    logic        en;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] gin;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
    logic [31:0] exp_dir;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0;
    m_dir = '0;
    pin_hist.delete();
    pin_hist.push_back(32'h0);
    pin_hist.push_back(32'h0);
  endtask

  function automatic logic [31:0] model_read(input logic sel, input logic wr, input logic [3:0] addr);
    logic [31:0] pins;
    pins = pin_hist[0];
    if (!(sel && !wr)) return 32'h0;
    case (addr)
      4'h0:    return ID;
      4'h1:    return (pins & ~m_dir) | (m_out & m_dir);
      4'h2:    return m_out;
      4'h3:    return m_dir;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one cycle (called just after a rising edge). Capture PRDATA
  // before the next edge, advance the model at the edge, then capture
  // the pin outputs just after it.
  task automatic apply(input logic sel, input logic en, input logic wr,
                       input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [31:0] gin,
                       output logic [31:0] rd, output logic [31:0] go,
                       output logic [31:0] gd);
    PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    gpio_in = gin;
    #2;
    rd = PRDATA;
    @(posedge PCLK);
    if (sel && en && wr) begin
      if (addr == 4'h2) m_out = wdata;
      else if (addr == 4'h3) m_dir = wdata;
    end
    pin_hist.push_back(gin);
    while (pin_hist.size() > 2) void'(pin_hist.pop_front());
    #1;
    go = gpio_out;
    gd = gpio_dir;
  endtask

  logic [31:0] rd, go, gd, exp_rd;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h2, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h3, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 4'h3, 32'h0F0FF0F5, 32'h0,        32'h0,        32'h0,        32'h0F0FF0F5};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'h2, 32'h01901573, 32'h0,        32'h0,        32'h01001071, 32'h0F0FF0F5};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'h3, 32'h0,        32'h0,        32'h0F0FF0F5, 32'h01001071, 32'h0F0FF0F5};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'h2, 32'h0,        32'h0,        32'h01901573, 32'h01001071, 32'h0F0FF0F5};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        ID,           32'h01001071, 32'h0F0FF0F5};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'h1, 32'h0,        32'hFFFFFFFF, 32'h01001071, 32'h01001071, 32'h0F0FF0F5};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'h1, 32'h0,        32'hFFFFFFFF, 32'h01001071, 32'h01001071, 32'h0F0FF0F5};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'h1, 32'h0,        32'hFFFFFFFF, 32'hF1F01F7B, 32'h01001071, 32'h0F0FF0F5};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 4'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h01001071, 32'h0F0FF0F5};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 4'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h01001071, 32'h0F0FF0F5};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 4'h7, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h01001071, 32'h0F0FF0F5};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 4'h2, 32'h0,        32'hFFFFFFFF, 32'h01901573, 32'h01001071, 32'h0F0FF0F5};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 4'h3, 32'h0,        32'hFFFFFFFF, 32'h0F0FF0F5, 32'h01001071, 32'h0F0FF0F5};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0F0FF0F5, 32'h0F0FF0F5};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 4'h3, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 4'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 4'h2, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 4'h3, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 4'h2, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 4'h1, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        32'h0};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 4'h1, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        32'h0};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 4'h1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0};

    PRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
    PWDATA = 32'h0; gpio_in = 32'h0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_gpio_dir", gpio_dir, 32'h0);
    check("rst_pready", {31'h0, PREADY}, 32'h1);
    check("rst_prdata_idle", PRDATA, 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    pin_hist.push_back(gpio_in);
    while (pin_hist.size() > 2) void'(pin_hist.pop_front());
    #1;

    // Directed table.
    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].sel, tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].gin, rd, go, gd);
      check($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_gpio_out", i), go, tbl[i].exp_out);
      check($sformatf("tbl%0d_gpio_dir", i), gd, tbl[i].exp_dir);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       sel, en, wr;
      logic [3:0] addr;
      logic [31:0] wd, gin;
      sel  = ($urandom_range(0, 7) != 0);
      en   = $urandom_range(0, 1) == 1;
      wr   = $urandom_range(0, 1) == 1;
      addr = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wd   = $urandom;
      gin  = $urandom;
      exp_rd = model_read(sel, wr, addr);
      apply(sel, en, wr, addr, wd, gin, rd, go, gd);
      check($sformatf("rnd%0d_prdata", i), rd, exp_rd);
      check($sformatf("rnd%0d_gpio_out", i), go, m_out & m_dir);
      check($sformatf("rnd%0d_gpio_dir", i), gd, m_dir);
    end

    // Reset asserted in the middle of a write transfer.
    apply(1'b1, 1'b1, 1'b1, 4'h3, 32'hFFFFFFFF, 32'h0, rd, go, gd);
    apply(1'b1, 1'b1, 1'b1, 4'h2, 32'h12345678, 32'h0, rd, go, gd);
    check("pre_rst_gpio_out", go, 32'h12345678);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 4'h2; PWDATA = 32'hAAAAAAAA;
    #2;
    PRESETn = 1'b0;
    #1;
    check("midrst_gpio_out", gpio_out, 32'h0);
    check("midrst_gpio_dir", gpio_dir, 32'h0);
    check("midrst_pready", {31'h0, PREADY}, 32'h1);
    check("midrst_prdata_write", PRDATA, 32'h0);
    @(posedge PCLK);
    #1;
    check("midrst_write_discarded", gpio_dir, 32'h0);
    PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 4'h0;
    #1;
    check("midrst_id_read", PRDATA, ID);
    @(negedge PCLK);
    PRESETn = 1'b1;
    model_reset();
    @(posedge PCLK);
    pin_hist.push_back(gpio_in);
    while (pin_hist.size() > 2) void'(pin_hist.pop_front());
    #1;
    apply(1'b1, 1'b1, 1'b0, 4'h2, 32'h0, 32'h0, rd, go, gd);
    check("postrst_read_out", rd, 32'h0);
    apply(1'b1, 1'b1, 1'b0, 4'h3, 32'h0, 32'h0, rd, go, gd);
    check("postrst_read_dir", rd, 32'h0);
    check("postrst_gpio_out", go, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
